// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage: RV32I/RV64I immediate extraction behind a 2-entry skid buffer.
// Optional build macro IMM_ILLEGAL_CHECK_EN adds out_illegal and forces flagged entries to NONE/0.
module imm_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
`ifdef IMM_ILLEGAL_CHECK_EN
    output logic            out_illegal,
`endif
    output logic [1:0]      state_dbg
);

    localparam logic [2:0] T_NONE  = 3'd0;
    localparam logic [2:0] T_I     = 3'd1;
    localparam logic [2:0] T_S     = 3'd2;
    localparam logic [2:0] T_B     = 3'd3;
    localparam logic [2:0] T_U     = 3'd4;
    localparam logic [2:0] T_J     = 3'd5;
    localparam logic [2:0] T_SHAMT = 3'd6;
    localparam bit         RV64    = (XLEN == 64);

    // Handshake: a beat moves on a rising edge where valid and ready are both high;
    // in_ready is registered and low only while the skid entry is occupied.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t            state;
    logic [31:0]       skid_inst;
    logic [XLEN-1:0]   skid_imm;
    logic [2:0]        skid_type;
    logic [6:0]        opc;
    logic [1:0]        f3lo;
    logic [31:0]       raw;
    logic              sext;
    logic [5:0]        shamt;
    logic [2:0]        dec_type;
    logic [XLEN-1:0]   dec_imm;
    logic              accept;
    logic              consume;

    assign opc       = in_inst[6:0];
    assign f3lo      = in_inst[13:12];
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;
    assign state_dbg = state;

    // raw holds the immediate sign-extended to 32 bits; widened to XLEN below.
    always_comb begin
        raw      = '0;
        sext     = 1'b1;
        shamt    = '0;
        dec_type = T_NONE;
        case (opc)
            7'b0110111, 7'b0010111: begin
                raw      = {in_inst[31:12], 12'h000};
                dec_type = T_U;
            end
            7'b1101111: begin
                raw      = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                            in_inst[30:21], 1'b0};
                dec_type = T_J;
            end
            7'b1100111, 7'b0000011: begin
                raw      = {{20{in_inst[31]}}, in_inst[31:20]};
                dec_type = T_I;
            end
            7'b0010011: begin
                if (f3lo == 2'b01) begin
                    sext     = 1'b0;
                    shamt    = RV64 ? in_inst[25:20] : {1'b0, in_inst[24:20]};
                    dec_type = T_SHAMT;
                end else begin
                    raw      = {{20{in_inst[31]}}, in_inst[31:20]};
                    dec_type = T_I;
                end
            end
            7'b0011011: begin
                if (RV64) begin
                    if (f3lo == 2'b01) begin
                        sext     = 1'b0;
                        shamt    = {1'b0, in_inst[24:20]};
                        dec_type = T_SHAMT;
                    end else begin
                        raw      = {{20{in_inst[31]}}, in_inst[31:20]};
                        dec_type = T_I;
                    end
                end
            end
            7'b0100011: begin
                raw      = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                dec_type = T_S;
            end
            7'b1100011: begin
                raw      = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                            in_inst[11:8], 1'b0};
                dec_type = T_B;
            end
            default: begin
                dec_type = T_NONE;
            end
        endcase
    end

`ifdef IMM_ILLEGAL_CHECK_EN
    logic            dec_illegal;
    logic            skid_illegal;
    logic [XLEN-1:0] fin_imm;
    logic [2:0]      fin_type;

    always_comb begin
        dec_illegal = (in_inst[1:0] != 2'b11);
        case (opc)
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b0000011, 7'b0100011, 7'b1100011: begin
                dec_illegal = dec_illegal;
            end
            7'b0010011: begin
                if (f3lo == 2'b01) begin
                    if (RV64)
                        dec_illegal = dec_illegal |
                            !((in_inst[31:26] == 6'b000000) || (in_inst[31:26] == 6'b010000));
                    else
                        dec_illegal = dec_illegal |
                            !((in_inst[31:25] == 7'b0000000) || (in_inst[31:25] == 7'b0100000));
                end
            end
            7'b0011011: begin
                if (!RV64)
                    dec_illegal = 1'b1;
                else if (f3lo == 2'b01)
                    dec_illegal = dec_illegal |
                        !((in_inst[31:25] == 7'b0000000) || (in_inst[31:25] == 7'b0100000));
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        fin_imm  = sext ? XLEN'($signed(raw)) : XLEN'(shamt);
        fin_type = dec_type;
        if (dec_illegal) begin
            fin_imm  = '0;
            fin_type = T_NONE;
        end
    end
    assign dec_imm = fin_imm;
`else
    assign dec_imm = sext ? XLEN'($signed(raw)) : XLEN'(shamt);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_imm   <= '0;
            out_type  <= T_NONE;
            skid_inst <= '0;
            skid_imm  <= '0;
            skid_type <= T_NONE;
`ifdef IMM_ILLEGAL_CHECK_EN
            out_illegal  <= 1'b0;
            skid_illegal <= 1'b0;
`endif
        end else if (flush) begin
            state     <= S_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        out_valid <= 1'b1;
                        out_inst  <= in_inst;
                        out_imm   <= dec_imm;
`ifdef IMM_ILLEGAL_CHECK_EN
                        out_type    <= fin_type;
                        out_illegal <= dec_illegal;
`else
                        out_type  <= dec_type;
`endif
                        state     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && consume) begin
                        out_inst <= in_inst;
                        out_imm  <= dec_imm;
`ifdef IMM_ILLEGAL_CHECK_EN
                        out_type    <= fin_type;
                        out_illegal <= dec_illegal;
`else
                        out_type <= dec_type;
`endif
                    end else if (accept) begin
                        skid_inst <= in_inst;
                        skid_imm  <= dec_imm;
`ifdef IMM_ILLEGAL_CHECK_EN
                        skid_type    <= fin_type;
                        skid_illegal <= dec_illegal;
`else
                        skid_type <= dec_type;
`endif
                        in_ready  <= 1'b0;
                        state     <= S_TWO;
                    end else if (consume) begin
                        out_valid <= 1'b0;
                        state     <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    // Older entry leaves; the skid entry becomes the head.
                    if (consume) begin
                        out_inst <= skid_inst;
                        out_imm  <= skid_imm;
                        out_type <= skid_type;
`ifdef IMM_ILLEGAL_CHECK_EN
                        out_illegal <= skid_illegal;
`endif
                        in_ready <= 1'b1;
                        state    <= S_ONE;
                    end
                end
                default: begin
                    state     <= S_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
